// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    ADC = 3'd1,
    SUB = 3'd2,
    SBC = 3'd3,
    AND = 3'd4,
    XOR = 3'd5,
    OR  = 3'd6,
    CP  = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  localparam int FLAG_S  = 7;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_Y  = 5;
  localparam int FLAG_H  = 4;
  localparam int FLAG_X  = 3;
  localparam int FLAG_PV = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_C  = 0;

  function automatic logic is_sub(input alu_op_t op);
    return op inside {SUB, SBC, CP};
  endfunction

  function automatic logic is_logic(input alu_op_t op);
    return op inside {AND, XOR, OR};
  endfunction

endpackage

// File: rtl/alu_nibble_core.sv
// Combinational 4-bit ALU slice; carries are raw adder carries (never borrow-inverted).
module alu_nibble_core
  import alu_seq_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  input  alu_op_t    i_op,
  output logic [3:0] o_res,
  output logic       o_cout,
  output logic       o_c3
);

  logic [3:0] w_b_eff;
  logic [3:0] w_lo;
  logic [4:0] w_sum;

  always_comb begin
    w_b_eff = is_sub(i_op) ? ~i_b : i_b;
    w_lo    = {1'b0, i_a[2:0]} + {1'b0, w_b_eff[2:0]} + {3'b000, i_cin};
    w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {4'b0000, i_cin};
    o_res   = w_sum[3:0];
    o_cout  = w_sum[4];
    o_c3    = w_lo[3];
    case (i_op)
      AND: begin o_res = i_a & i_b; o_cout = 1'b0; o_c3 = 1'b0; end
      XOR: begin o_res = i_a ^ i_b; o_cout = 1'b0; o_c3 = 1'b0; end
      OR:  begin o_res = i_a | i_b; o_cout = 1'b0; o_c3 = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// Multi-nibble ALU sequencer: one nibble per clock, low nibble first,
// Z80-style flag byte registered together with the result on the final nibble.
module alu_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             cf_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [7:0]       flags
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = $clog2(NIB);

  alu_state_t       r_state, w_next;
  logic [IDX_W-1:0] r_idx;
  alu_op_t          r_op;
  logic [WIDTH-1:0] r_a, r_b, r_shadow;
  logic             r_cf, r_carry, r_h, r_nz, r_par;

  logic             w_accept, w_last, w_sub, w_c0, w_cin;
  logic [3:0]       w_na, w_nb, w_nres;
  logic             w_cout, w_c3;
  logic [WIDTH-1:0] w_full;
  logic [7:0]       w_flags;

  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_idx == IDX_W'(NIB - 1));
  assign w_sub    = is_sub(r_op);
  assign w_na     = r_a[{r_idx, 2'b00} +: 4];
  assign w_nb     = r_b[{r_idx, 2'b00} +: 4];
  assign w_cin    = (r_idx == '0) ? w_c0 : r_carry;
  // Shadow fills from the top, so after the last nibble it is fully aligned.
  assign w_full   = {w_nres, r_shadow[WIDTH-1:4]};

  alu_nibble_core u_core (
    .i_a    (w_na),
    .i_b    (w_nb),
    .i_cin  (w_cin),
    .i_op   (r_op),
    .o_res  (w_nres),
    .o_cout (w_cout),
    .o_c3   (w_c3)
  );

  always_comb begin
    case (r_op)
      ADC:     w_c0 = r_cf;
      SUB, CP: w_c0 = 1'b1;
      SBC:     w_c0 = ~r_cf;
      default: w_c0 = 1'b0;
    endcase
  end

  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_S] = w_full[WIDTH-1];
    w_flags[FLAG_Z] = ~(r_nz | (|w_nres));
    w_flags[FLAG_Y] = w_full[5];
    w_flags[FLAG_X] = w_full[3];
    if (is_logic(r_op)) begin
      w_flags[FLAG_H]  = (r_op == AND);
      w_flags[FLAG_PV] = ~(r_par ^ (^w_nres));
    end else begin
      // Subtracts run as a + ~b + 1, so inverting the raw carries yields borrows.
      w_flags[FLAG_H]  = r_h ^ w_sub;
      w_flags[FLAG_PV] = w_c3 ^ w_cout;
      w_flags[FLAG_N]  = w_sub;
      w_flags[FLAG_C]  = w_cout ^ w_sub;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = start ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx    <= '0;
      r_op     <= ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_cf     <= 1'b0;
      r_carry  <= 1'b0;
      r_h      <= 1'b0;
      r_nz     <= 1'b0;
      r_par    <= 1'b0;
      r_shadow <= '0;
      result   <= '0;
      flags    <= '0;
    end else if (w_accept) begin
      r_op  <= alu_op_t'(op);
      r_a   <= op1;
      r_b   <= op2;
      r_cf  <= cf_in;
      r_idx <= '0;
      r_nz  <= 1'b0;
      r_par <= 1'b0;
    end else if (r_state == RUN) begin
      r_idx    <= r_idx + IDX_W'(1);
      r_carry  <= w_cout;
      r_shadow <= w_full;
      r_nz     <= r_nz | (|w_nres);
      r_par    <= r_par ^ (^w_nres);
      if (r_idx == '0) r_h <= w_cout;
      if (w_last) begin
        result <= (r_op == CP) ? r_a : w_full;
        flags  <= w_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench: 8- and 16-bit instances against an integer-arithmetic flag model.
module tb_alu_nibble_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        s8_start, s8_cf;
  logic [2:0]  s8_op;
  logic [7:0]  s8_a, s8_b, s8_res, s8_fl;
  logic        s8_busy, s8_done;

  logic        s16_start, s16_cf;
  logic [2:0]  s16_op;
  logic [15:0] s16_a, s16_b, s16_res;
  logic [7:0]  s16_fl;
  logic        s16_busy, s16_done;

  int total = 0;
  int bad   = 0;

  alu_nibble_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(s8_start), .op(s8_op), .op1(s8_a), .op2(s8_b),
    .cf_in(s8_cf), .busy(s8_busy), .done(s8_done), .result(s8_res), .flags(s8_fl)
  );

  alu_nibble_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(s16_start), .op(s16_op), .op1(s16_a), .op2(s16_b),
    .cf_in(s16_cf), .busy(s16_busy), .done(s16_done), .result(s16_res), .flags(s16_fl)
  );

  // Reference: plain integer arithmetic over the whole word.
  function automatic void model(input int w, input logic [2:0] op, input logic [15:0] a,
                                input logic [15:0] b, input logic cf,
                                output logic [15:0] res, output logic [7:0] fl);
    longint m, ua, ub, sa, sb, r, sr, v, bw;
    logic c, h, pv, n;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    c = 0; h = 0; pv = 0; n = 0;
    case (op)
      3'd0, 3'd1: begin
        bw = (op == 3'd1) ? longint'(cf) : 0;
        r  = ua + ub + bw;
        c  = (r >= m);
        h  = ((ua & 15) + (ub & 15) + bw) > 15;
        sr = sa + sb + bw;
        pv = (sr >= m / 2) || (sr < -(m / 2));
        v  = r & (m - 1);
      end
      3'd2, 3'd3, 3'd7: begin
        bw = (op == 3'd3) ? longint'(cf) : 0;
        r  = ua - ub - bw;
        c  = (r < 0);
        h  = ((ua & 15) - (ub & 15) - bw) < 0;
        sr = sa - sb - bw;
        pv = (sr >= m / 2) || (sr < -(m / 2));
        n  = 1;
        v  = (r < 0) ? r + m : r;
      end
      default: begin
        if (op == 3'd4)      v = ua & ub;
        else if (op == 3'd5) v = ua ^ ub;
        else                 v = ua | ub;
        h  = (op == 3'd4);
        pv = ($countones(v) % 2) == 0;
      end
    endcase
    res = (op == 3'd7) ? ua[15:0] : v[15:0];
    fl  = {v[w-1], (v == 0), v[5], h, v[3], pv, n, c};
  endfunction

  task automatic run_op(input bit wide, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic cf,
                        output logic [15:0] res, output logic [7:0] fl, output int lat);
    @(negedge clk);
    if (wide) begin
      s16_op = op; s16_a = a; s16_b = b; s16_cf = cf; s16_start = 1'b1;
    end else begin
      s8_op = op; s8_a = a[7:0]; s8_b = b[7:0]; s8_cf = cf; s8_start = 1'b1;
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      s8_start = 1'b0; s16_start = 1'b0;
    end while (!(wide ? s16_done : s8_done) && lat < 20);
    res = wide ? s16_res : {8'h00, s8_res};
    fl  = wide ? s16_fl : s8_fl;
  endtask

  task automatic check_op(input string name, input bit wide, input logic [2:0] op,
                          input logic [15:0] a, input logic [15:0] b, input logic cf);
    logic [15:0] res, eres;
    logic [7:0]  fl, efl;
    int lat, elat;
    run_op(wide, op, a, b, cf, res, fl, lat);
    model(wide ? 16 : 8, op, a, b, cf, eres, efl);
    elat = wide ? 5 : 3;
    total++;
    if (lat !== elat) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, elat);
    end
    total++;
    if (res !== eres) begin
      bad++; $display("FAIL %s result: got %h want %h", name, res, eres);
    end
    total++;
    if (fl !== efl) begin
      bad++; $display("FAIL %s flags: got %b want %b", name, fl, efl);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    s8_start = 0; s8_op = 0; s8_a = 0; s8_b = 0; s8_cf = 0;
    s16_start = 0; s16_op = 0; s16_a = 0; s16_b = 0; s16_cf = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if ({s8_busy, s8_done, s8_res, s8_fl} !== 18'h0) begin
      bad++; $display("FAIL reset8: got %b_%b_%h_%h want all zero", s8_busy, s8_done, s8_res, s8_fl);
    end
    total++;
    if ({s16_busy, s16_done, s16_res, s16_fl} !== 26'h0) begin
      bad++; $display("FAIL reset16: got %b_%b_%h_%h want all zero", s16_busy, s16_done, s16_res, s16_fl);
    end
  endtask

  task automatic test_directed;
    logic [15:0] res;
    logic [7:0]  fl;
    int lat;
    check_op("add8c6d", 0, 3'd0, 16'h008C, 16'h006D, 0);
    check_op("add7f01", 0, 3'd0, 16'h007F, 16'h0001, 0);
    check_op("sub16",   1, 3'd2, 16'h0000, 16'h0001, 0);
    check_op("adc8",    0, 3'd1, 16'h00FF, 16'h0000, 1);
    check_op("sbc16",   1, 3'd3, 16'h8000, 16'h0000, 1);
    check_op("and16",   1, 3'd4, 16'hF0F3, 16'h3F35, 0);
    check_op("or8",     0, 3'd6, 16'h0021, 16'h0010, 0);
    // Fixed expectations straight from the worked examples.
    run_op(0, 3'd0, 16'h008C, 16'h006D, 0, res, fl, lat);
    total++;
    if ({res[7:0], fl} !== {8'hF9, 8'b1011_1000}) begin
      bad++; $display("FAIL add8_const: got %h/%b want f9/10111000", res[7:0], fl);
    end
    run_op(1, 3'd2, 16'h0000, 16'h0001, 0, res, fl, lat);
    total++;
    if ({res, fl} !== {16'hFFFF, 8'b1011_1011}) begin
      bad++; $display("FAIL sub16_const: got %h/%b want ffff/10111011", res, fl);
    end
  endtask

  task automatic test_random;
    logic [15:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 7 == 3) b = a;
      if (i % 11 == 5) a = 16'hFFFF;
      check_op("rand", i[0], 3'($urandom_range(0, 7)), a, b, 1'($urandom));
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] eres;
    logic [7:0]  efl;
    int lat;
    @(negedge clk);
    s16_op = 3'd5; s16_a = 16'hA5A5; s16_b = 16'hA5A5; s16_cf = 0; s16_start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++; s16_start = 1'b0;
    end while (!s16_done && lat < 20);
    total++;
    if ({s16_res, s16_fl[6], s16_fl[4], s16_fl[2], s16_fl[0]} !== {16'h0000, 4'b1010}) begin
      bad++; $display("FAIL b2b_xor: got %h/%b want 0000 Z=1 H=0 PV=1 C=0", s16_res, s16_fl);
    end
    // Raise the next request while still in the DONE cycle.
    s16_op = 3'd7; s16_a = 16'h1234; s16_b = 16'h1234; s16_start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++; s16_start = 1'b0;
    end while (!s16_done && lat < 20);
    model(16, 3'd7, 16'h1234, 16'h1234, 0, eres, efl);
    total++;
    if (lat !== 5) begin
      bad++; $display("FAIL b2b_latency: got %0d want 5", lat);
    end
    total++;
    if ({s16_res, s16_fl[6], s16_fl[1]} !== {16'h1234, 2'b11}) begin
      bad++; $display("FAIL b2b_cp: got %h/%b want 1234 Z=1 N=1", s16_res, s16_fl);
    end
    total++;
    if (s16_fl !== efl) begin
      bad++; $display("FAIL b2b_cp_flags: got %b want %b", s16_fl, efl);
    end
  endtask

  task automatic test_start_in_run;
    logic [15:0] eres;
    logic [7:0]  efl;
    int dones;
    model(16, 3'd0, 16'h1F2E, 16'h0E1D, 0, eres, efl);
    @(negedge clk);
    s16_op = 3'd0; s16_a = 16'h1F2E; s16_b = 16'h0E1D; s16_cf = 0; s16_start = 1'b1;
    @(posedge clk); #1;
    s16_op = 3'd2; s16_a = 16'hFFFF; s16_b = 16'h0001;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) s16_start = 1'b0;
      if (s16_done) begin
        dones++;
        total++;
        if ({s16_res, s16_fl} !== {eres, efl}) begin
          bad++; $display("FAIL run_ignore_result: got %h/%b want %h/%b", s16_res, s16_fl, eres, efl);
        end
      end
    end
    total++;
    if (dones !== 1) begin
      bad++; $display("FAIL run_ignore_dones: got %0d want 1", dones);
    end
  endtask

  task automatic test_reset_mid_run;
    int dones;
    @(negedge clk);
    s16_op = 3'd0; s16_a = 16'h0001; s16_b = 16'h0002; s16_start = 1'b1;
    @(posedge clk); #1 s16_start = 1'b0;
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({s16_busy, s16_done, s16_res, s16_fl} !== 26'h0) begin
      bad++; $display("FAIL reset_mid_run: got %b_%b_%h_%h want all zero", s16_busy, s16_done, s16_res, s16_fl);
    end
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (s16_done || s16_busy) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++; $display("FAIL reset_no_done: got %0d active cycles want 0", dones);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_start_in_run();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
